// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around mem_arbiter.
// The master modport is the arbiter's view; slave is the CPU/memory environment.
interface mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_ack;
    logic [DW-1:0] i_rdata;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;
    logic [DW-1:0] d_rdata;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    logic          busy;
    logic          owner;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
        busy, owner
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata,
        busy, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data access.
// Data has priority; a saturating starvation counter forces a fetch grant.
module mem_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic           clk,
    input logic           rst,
    mem_arbiter_if.master bus
);
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] Limit = CW'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e        state_q, state_d;
    logic          owner_q, owner_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          fetch_forced;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        starve_d     = starve_q;
        fetch_forced = bus.i_req && (starve_q == Limit);

        unique case (state_q)
            StIdle: begin
                if (bus.d_req && !fetch_forced) begin
                    state_d     = StBusy;
                    owner_d     = 1'b1;
                    mem_addr_d  = bus.d_addr;
                    mem_we_d    = bus.d_we;
                    mem_wdata_d = bus.d_wdata;
                    // Count only data grants that made a waiting fetch wait longer
                    if (!bus.i_req) begin
                        starve_d = '0;
                    end else if (starve_q != Limit) begin
                        starve_d = starve_q + CW'(1);
                    end
                end else if (bus.i_req) begin
                    state_d     = StBusy;
                    owner_d     = 1'b0;
                    mem_addr_d  = bus.i_addr;
                    mem_we_d    = 1'b0;
                    mem_wdata_d = '0;
                    starve_d    = '0;
                end
            end
            StBusy: begin
                if (bus.mem_ready) begin
                    state_d = StResp;
                    if (!owner_q) begin
                        i_rdata_d = bus.mem_rdata;
                    end else if (!mem_we_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            starve_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            starve_q    <= starve_d;
        end
    end

    // Handshake outputs decode straight from the state register, so reset clears them at once
    assign bus.mem_req   = (state_q == StBusy);
    assign bus.i_ack     = (state_q == StResp) && !owner_q;
    assign bus.d_ack     = (state_q == StResp) && owner_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.owner     = owner_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a transaction-level memory/arbitration model.
module tb_mem_arbiter;
    localparam int LIMIT = 4;

    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    mem_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        preload;
        logic [31:0] pdata;
        int          wait_c;
        logic [31:0] exp_rdata;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] mem_arr [logic [31:0]];

    bit          rand_mode;
    int          fixed_wait;
    int          starve_m;
    logic        prev_mem_req, prev_busy;
    logic        g_owner, g_we;
    logic [31:0] g_addr, g_wdata;
    int          wait_tgt, wait_cnt, ready_cycle;
    logic [31:0] exp_i_rdata, exp_d_rdata;
    int          i_acks, d_acks;
    int          ack_log[$];

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return (a * 32'h9E3779B9) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [31:0] rnd_addr();
        return 32'($urandom_range(15, 0)) << 2;
    endfunction

    task automatic model_reset();
        starve_m     = 0;
        prev_mem_req = 1'b0;
        prev_busy    = 1'b0;
        ready_cycle  = -100;
        exp_i_rdata  = '0;
        exp_d_rdata  = '0;
    endtask

    // One cycle: observe outputs at the falling edge, then play the memory.
    // Requester inputs still hold the values the DUT sampled on the last rising edge.
    task automatic tick();
        logic win_data;
        logic any_req;
        @(negedge clk);
        cyc++;
        any_req = bus.i_req || bus.d_req;
        if (rst) begin
            check1("ack_overlap", bus.i_ack && bus.d_ack, 1'b0);
            check1("busy", bus.busy, bus.mem_req || bus.i_ack || bus.d_ack);
            if (!prev_busy && any_req) check1("grant_taken", bus.mem_req, 1'b1);
            if (bus.mem_req && !prev_mem_req) begin
                check1("grant_has_req", any_req, 1'b1);
                win_data = bus.d_req && !(bus.i_req && (starve_m == LIMIT));
                if (!win_data) starve_m = 0;
                else if (!bus.i_req) starve_m = 0;
                else if (starve_m < LIMIT) starve_m = starve_m + 1;
                g_owner  = win_data;
                g_addr   = win_data ? bus.d_addr : bus.i_addr;
                g_we     = win_data && bus.d_we;
                g_wdata  = win_data ? bus.d_wdata : 32'h0;
                wait_tgt = rand_mode ? int'($urandom_range(3, 0)) : fixed_wait;
                wait_cnt = 0;
            end
            if (bus.i_ack || bus.d_ack) begin
                check_int("ack_after_ready", cyc, ready_cycle + 1);
                check1("ack_owner", bus.d_ack, g_owner);
                check1("owner_at_ack", bus.owner, g_owner);
                if (bus.i_ack) begin
                    exp_i_rdata = mem_read(g_addr);
                    i_acks++;
                    ack_log.push_back(0);
                end else begin
                    if (!g_we) exp_d_rdata = mem_read(g_addr);
                    d_acks++;
                    ack_log.push_back(1);
                end
            end
            check32("i_rdata", bus.i_rdata, exp_i_rdata);
            check32("d_rdata", bus.d_rdata, exp_d_rdata);
            if (bus.mem_req) begin
                check32("mem_addr_stable", bus.mem_addr, g_addr);
                check1("mem_we_stable", bus.mem_we, g_we);
                check32("mem_wdata_stable", bus.mem_wdata, g_wdata);
                check1("owner_busy", bus.owner, g_owner);
                if (wait_cnt >= wait_tgt) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = mem_read(bus.mem_addr);
                    if (bus.mem_we) mem_arr[bus.mem_addr] = bus.mem_wdata;
                    ready_cycle = cyc;
                end else begin
                    bus.mem_ready = 1'b0;
                    bus.mem_rdata = $urandom;
                    wait_cnt++;
                end
            end else begin
                bus.mem_ready = rand_mode ? 1'($urandom_range(1, 0)) : 1'b0;
                bus.mem_rdata = $urandom;
            end
        end
        prev_mem_req = bus.mem_req;
        prev_busy    = bus.busy;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int c0, ack_c, req_cycles;
        if (v.preload) mem_arr[v.addr] = v.pdata;
        fixed_wait = v.wait_c;
        tick();
        if (v.is_data) begin
            bus.d_req   = 1'b1;
            bus.d_we    = v.we;
            bus.d_addr  = v.addr;
            bus.d_wdata = v.wdata;
        end else begin
            bus.i_req  = 1'b1;
            bus.i_addr = v.addr;
        end
        c0         = cyc;
        ack_c      = -1;
        req_cycles = 0;
        for (int k = 0; k < 30 && ack_c < 0; k++) begin
            tick();
            if (bus.mem_req) req_cycles++;
            if (cyc == c0 + 1) begin
                check1({nm, "_mem_req_c1"}, bus.mem_req, 1'b1);
                check32({nm, "_mem_addr_c1"}, bus.mem_addr, v.addr);
            end
            if (bus.i_ack || bus.d_ack) begin
                ack_c     = cyc;
                bus.i_req = 1'b0;
                bus.d_req = 1'b0;
            end
        end
        check_int({nm, "_latency"}, ack_c - c0, 2 + v.wait_c);
        check_int({nm, "_mem_req_cycles"}, req_cycles, v.wait_c + 1);
        check32({nm, "_rdata"}, v.is_data ? bus.d_rdata : bus.i_rdata, v.exp_rdata);
        tick();
        check1({nm, "_idle_after"}, bus.busy, 1'b0);
        tick();
    endtask

    vec_t vecs[7];

    initial begin
        int dc, ic, i_wait, max_i_wait, i0, d0;
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dc, ic, i_wait, max_i_wait, i0, d0;
        vecs[0] = '{1'b0, 1'b0, 32'h10,       32'h0,        1'b1, 32'h1234ABCD, 0, 32'h1234ABCD};
        vecs[1] = '{1'b1, 1'b0, 32'h40,       32'h0,        1'b1, 32'hCAFEF00D, 2, 32'hCAFEF00D};
        vecs[2] = '{1'b1, 1'b1, 32'h20,       32'hDEADBEEF, 1'b0, 32'h0,        3, 32'hCAFEF00D};
        vecs[3] = '{1'b1, 1'b0, 32'h20,       32'h0,        1'b0, 32'h0,        0, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h0BADC0DE, 1, 32'h0BADC0DE};
        vecs[5] = '{1'b1, 1'b0, 32'h0,        32'h0,        1'b1, 32'h13579BDF, 5, 32'h13579BDF};
        vecs[6] = '{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 32'h0F0F0F0F, 0, 32'h0F0F0F0F};

        rand_mode     = 1'b0;
        fixed_wait    = 0;
        i_acks        = 0;
        d_acks        = 0;
        bus.i_req     = 1'b0;
        bus.i_addr    = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        model_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        check1("rst_mem_req", bus.mem_req, 1'b0);
        check1("rst_busy", bus.busy, 1'b0);
        check1("rst_owner", bus.owner, 1'b0);
        check1("rst_acks", bus.i_ack || bus.d_ack, 1'b0);
        check1("rst_mem_we", bus.mem_we, 1'b0);
        check32("rst_mem_addr", bus.mem_addr, 32'h0);
        check32("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check32("rst_rdata", bus.i_rdata | bus.d_rdata, 32'h0);
        tick();
        tick();
        rst = 1'b1;

        for (int v = 0; v < 6; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

        // Simultaneous requests: data first, fetch granted right after d_ack
        fixed_wait = 0;
        tick();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h80;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h40;
        dc = -1;
        ic = -1;
        for (int k = 0; k < 30 && (dc < 0 || ic < 0); k++) begin
            tick();
            if (bus.d_ack) begin
                dc = cyc;
                bus.d_req = 1'b0;
            end
            if (bus.i_ack) begin
                ic = cyc;
                bus.i_req = 1'b0;
            end
        end
        check1("simul_data_first", (dc > 0) && (dc < ic), 1'b1);
        check_int("simul_fetch_gap", ic - dc, 3);
        tick();

        // Starvation: both held high; data LIMIT times, then one fetch
        ack_log.delete();
        tick();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h100;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h200;
        for (int k = 0; k < 200 && ack_log.size() < 15; k++) begin
            tick();
            if (bus.i_ack) bus.i_addr = bus.i_addr + 32'h4;
            if (bus.d_ack) bus.d_addr = bus.d_addr + 32'h4;
            if (ack_log.size() >= 15) begin
                bus.i_req = 1'b0;
                bus.d_req = 1'b0;
            end
        end
        check_int("starve_ack_count", ack_log.size(), 15);
        for (int k = 0; k < 15 && k < ack_log.size(); k++)
            check_int($sformatf("starve_seq%0d", k), ack_log[k], (k % (LIMIT + 1) == LIMIT) ? 0 : 1);
        tick();
        tick();

        // Reset in the middle of a stalled load
        fixed_wait = 6;
        tick();
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h44;
        tick();
        tick();
        tick();
        check1("busy_before_reset", bus.busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        check1("rst_mid_mem_req", bus.mem_req, 1'b0);
        check1("rst_mid_busy", bus.busy, 1'b0);
        check1("rst_mid_acks", bus.i_ack || bus.d_ack, 1'b0);
        check1("rst_mid_owner", bus.owner, 1'b0);
        check32("rst_mid_d_rdata", bus.d_rdata, 32'h0);
        check32("rst_mid_mem_addr", bus.mem_addr, 32'h0);
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b0;
        model_reset();
        tick();
        tick();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check1("no_ack_after_reset", bus.i_ack || bus.d_ack, 1'b0);
        end
        run_vec(vecs[6], "post_reset_fetch");

        // Randomized traffic with random memory latency and stray mem_ready
        rand_mode  = 1'b1;
        i_wait     = 0;
        max_i_wait = 0;
        i0         = i_acks;
        d0         = d_acks;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (bus.i_ack) i_wait = 0;
            else if (bus.i_req) i_wait++;
            if (i_wait > max_i_wait) max_i_wait = i_wait;
            if (bus.i_ack) begin
                if ($urandom_range(1, 0) == 1) bus.i_addr = rnd_addr();
                else bus.i_req = 1'b0;
            end else if (!bus.i_req && $urandom_range(2, 0) == 0) begin
                bus.i_req  = 1'b1;
                bus.i_addr = rnd_addr();
            end
            if (bus.d_ack) begin
                if ($urandom_range(3, 0) != 0) begin
                    bus.d_we    = 1'($urandom_range(1, 0));
                    bus.d_addr  = rnd_addr();
                    bus.d_wdata = $urandom;
                end else begin
                    bus.d_req = 1'b0;
                end
            end else if (!bus.d_req && $urandom_range(1, 0) == 0) begin
                bus.d_req   = 1'b1;
                bus.d_we    = 1'($urandom_range(1, 0));
                bus.d_addr  = rnd_addr();
                bus.d_wdata = $urandom;
            end
        end
        check1("fetch_wait_bound", max_i_wait <= (LIMIT + 2) * 6, 1'b1);
        check1("random_fetch_acks", (i_acks - i0) > 0, 1'b1);
        check1("random_data_acks", (d_acks - d0) > 0, 1'b1);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        for (int k = 0; k < 20 && (bus.busy || bus.i_ack || bus.d_ack); k++) tick();
        tick();
        check1("final_idle", bus.busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares a single memory port between the CPU's instruction-fetch path (PC-addressed) and its data path (load/store from the ALU and register file). It sits between the `cpu` datapath and the memory.
- Each requester sees a simple req/ack handshake.
- The memory sees one registered request at a time, with a variable-latency ready.
- Data accesses have priority; a counter guarantees fetch progress.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width
- STARVE_LIMIT, 4, maximum consecutive data grants while fetch is waiting (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- i_req  in  1  fetch request, held until i_ack
- i_addr  in  AW  fetch address, stable while i_req
- i_ack  out  1  one-cycle pulse, fetch complete
- i_rdata  out  DW  fetched word, valid with i_ack, held until next fetch completes
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load, stable while d_req
- d_addr  in  AW  data address, stable while d_req
- d_wdata  in  DW  store data, stable while d_req
- d_ack  out  1  one-cycle pulse, data access complete
- d_rdata  out  DW  load result, valid with d_ack, held until next load completes
- mem_req  out  1  memory request, held until mem_ready sampled high
- mem_we  out  1  write strobe qualifier
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory completion, sampled only while mem_req=1
- busy  out  1  1 whenever state ≠ IDLE
- owner  out  1  0 = fetch, 1 = data; owner of current/last grant

## Operation
States:
- IDLE: no transaction in progress; arbitration happens here.
- BUSY: memory transaction outstanding.
- RESP: acknowledge to the winning requester.

Arbitration in IDLE:
- Data wins if d_req=1, unless i_req=1 and starve_cnt==STARVE_LIMIT; then fetch wins.
- Otherwise fetch wins if i_req=1.
- With no request, remain in IDLE.

On grant (IDLE→BUSY):
- Register the winner's address into mem_addr.
- For a data grant, also register we/wdata into mem_we/mem_wdata.
- For a fetch grant, mem_we=0 and mem_wdata is don't-care (driven 0).
- Set mem_req=1 and set owner.

starve_cnt update, applied on each grant:
- Fetch grant: 0.
- Data grant with i_req=1: +1, saturating at STARVE_LIMIT.
- Data grant with i_req=0: 0.

BUSY:
- mem_req and all mem_* outputs stay constant until mem_ready=1.
- In that cycle, capture mem_rdata into i_rdata (fetch) or d_rdata (data load only).
- Stores leave d_rdata unchanged.
- Next state RESP; mem_req drops to 0.

RESP:
- i_ack or d_ack (per owner) is 1 for exactly this cycle.
- Next state IDLE.

Other rules:
- i_ack and d_ack are never asserted together; at most one memory transaction is ever outstanding.
- Requester may keep req high after ack to issue a new access; it is sampled in the following IDLE cycle.
- mem_ready while mem_req=0 is ignored.

Reset (asynchronous, any state, including mid-transaction):
- state=IDLE, starve_cnt=0.
- All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, i_ack, d_ack, i_rdata, d_rdata, busy, owner.
- Any outstanding memory access is abandoned; no ack is produced for it.

## Timing
- Cycle 0: IDLE samples req.
- Cycle 1: mem_req=1.
- If mem_ready=1 in cycle 1+k (k≥0 wait cycles), the ack is in cycle 2+k.
- Next IDLE is cycle 3+k. Minimum request-to-ack latency is 2 cycles.
- Peak throughput is one access per 3 cycles.
- Same-cycle i_req and d_req in IDLE: data granted first. Fetch is granted in the IDLE immediately after d_ack, unless d_req is still high and starve_cnt<STARVE_LIMIT.
- Worst-case fetch wait: STARVE_LIMIT data transactions.
- busy=1 from the grant cycle+1 through RESP inclusive.

## Test plan
- **Single fetch:**
  - Stimulus: i_req=1, i_addr=0x10, mem_ready tied 1, mem_rdata=0x1234ABCD.
  - Response: mem_req=1/mem_addr=0x10 in cycle 1; i_ack=1, i_rdata=0x1234ABCD in cycle 2; busy=0 in cycle 3.
- **Simultaneous requests:**
  - Stimulus: i_req and d_req rise in the same cycle (d_we=0, d_addr=0x40).
  - Response: d_ack precedes i_ack; owner sequence 1 then 0; acks never overlap.
- **Starvation:**
  - Stimulus: STARVE_LIMIT=4; d_req and i_req held continuously.
  - Response: exactly 4 d_acks, then 1 i_ack, then data again; pattern repeats.
- **Stalled store:**
  - Stimulus: d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF; mem_ready low for 3 cycles.
  - Response: mem_req/mem_we/mem_addr/mem_wdata stable for 4 cycles; single d_ack; d_rdata keeps its prior value.
- **Reset mid-transaction:**
  - Stimulus: drop rst while in BUSY.
  - Response: mem_req, busy and acks go 0 immediately without a clock; no ack is issued.
  - Follow-up: after release, a fetch to 0x0 completes with normal 2-cycle latency.
